// File: rtl/gate_tt_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// gate_tt_sequencer_pkg -- FSM state encoding and reference truth tables
// Rev 1.0
// =============================================================================
package gate_tt_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Bit k of each table is the gate output for input vector k.
    localparam logic [15:0] TT_AND4  = 16'h8000;
    localparam logic [15:0] TT_OR4   = 16'hFFFE;
    localparam logic [15:0] TT_NAND4 = 16'h7FFF;
    localparam logic [15:0] TT_XOR4  = 16'h6996;

    localparam logic [3:0]  LAST_IDX = 4'd15;

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// =============================================================================
// settle_timer -- 4-bit settle counter, expires after SETTLE counted cycles
// Rev 1.0
// =============================================================================
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 4'd0;
        end else if (en) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 4'(SETTLE - 1));

endmodule
`default_nettype wire

// File: rtl/gate_tt_sequencer.sv
`default_nettype none
// =============================================================================
// gate_tt_sequencer -- sweeps 16 vectors through a 4-input GUT, checks table
// Rev 1.0
// =============================================================================
module gate_tt_sequencer
    import gate_tt_sequencer_pkg::*;
#(
    parameter int          SETTLE   = 1,
    parameter logic [15:0] EXPECTED = TT_AND4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  gate_in,
    input  logic        gate_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        pass
);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  gate_in_q, gate_in_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] table_q, table_d;
    logic        pass_q, pass_d;
    logic        tmr_load;
    logic        tmr_en;
    logic        tmr_expired;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gate_in_d = gate_in_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        table_d   = table_q;
        pass_d    = pass_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gate_in_d = 4'd0;
                busy_d    = 1'b0;
                if (start) begin
                    state_d  = ST_SETTLE;
                    idx_d    = 4'd0;
                    tmr_load = 1'b1;
                    table_d  = 16'h0000;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                table_d[idx_q] = gate_out;
                if (idx_q == LAST_IDX) begin
                    // Pass is resolved on the edge into DONE so it is valid alongside done.
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (table_d == EXPECTED);
                end else begin
                    state_d   = ST_SETTLE;
                    idx_d     = idx_q + 4'd1;
                    gate_in_d = idx_q + 4'd1;
                    tmr_load  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                gate_in_d = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            gate_in_q <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            table_q   <= 16'h0000;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gate_in_q <= gate_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            table_q   <= table_d;
            pass_q    <= pass_d;
        end
    end

    assign gate_in   = gate_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign pass      = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_tt_sequencer.sv
`default_nettype none
// =============================================================================
// tb_gate_tt_sequencer -- three sequencer instances (AND4/S1, OR4/S1, AND4/S3)
// Rev 1.0
// =============================================================================
module tb_gate_tt_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode_zero;
    logic [3:0]  gin [3];
    logic        gout [3];
    logic        busy [3];
    logic        done [3];
    logic [15:0] tbl [3];
    logic        pass [3];
    logic [3:0]  prev_gin2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gate_tt_sequencer #(.SETTLE(1), .EXPECTED(16'h8000)) dut_a (
        .clk(clk), .rst(rst), .start(start), .gate_in(gin[0]), .gate_out(gout[0]),
        .busy(busy[0]), .done(done[0]), .table_out(tbl[0]), .pass(pass[0]));
    gate_tt_sequencer #(.SETTLE(1), .EXPECTED(16'hFFFE)) dut_o (
        .clk(clk), .rst(rst), .start(start), .gate_in(gin[1]), .gate_out(gout[1]),
        .busy(busy[1]), .done(done[1]), .table_out(tbl[1]), .pass(pass[1]));
    gate_tt_sequencer #(.SETTLE(3), .EXPECTED(16'h8000)) dut_s (
        .clk(clk), .rst(rst), .start(start), .gate_in(gin[2]), .gate_out(gout[2]),
        .busy(busy[2]), .done(done[2]), .table_out(tbl[2]), .pass(pass[2]));

    // GUTs: AND4 (or stuck-at-0), OR4, and an AND4 that is wrong in each vector's first cycle.
    always @(posedge clk) prev_gin2 <= gin[2];
    assign gout[0] = mode_zero ? 1'b0 : (&gin[0]);
    assign gout[1] = |gin[1];
    assign gout[2] = (&gin[2]) ^ (gin[2] != prev_gin2);

    function automatic int settle_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction

    function automatic logic [15:0] exp_of(input int i);
        return (i == 1) ? 16'hFFFE : 16'h8000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: k = cycles since the accepting edge (0 = idle); sweep length is 16*(S+1).
    int          mk [3];
    logic [15:0] mt [3];
    logic        mp [3];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            int s;
            int len;
            s   = settle_of(i);
            len = 16 * (s + 1);
            if (rst) begin
                mk[i] = 0;
                mt[i] = 16'h0000;
                mp[i] = 1'b0;
            end else if (mk[i] == 0) begin
                if (start) begin
                    mk[i] = 1;
                    mt[i] = 16'h0000;
                    mp[i] = 1'b0;
                end
            end else if (mk[i] <= len) begin
                if ((mk[i] - 1) % (s + 1) == s) mt[i][(mk[i] - 1) / (s + 1)] = gout[i];
                if (mk[i] == len) mp[i] = (mt[i] == exp_of(i));
                mk[i] = mk[i] + 1;
            end else begin
                mk[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                int s;
                int len;
                s   = settle_of(i);
                len = 16 * (s + 1);
                check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(mk[i] >= 1 && mk[i] <= len));
                check($sformatf("done[%0d]", i), 32'(done[i]), 32'(mk[i] == len + 1));
                check($sformatf("pass[%0d]", i), 32'(pass[i]), 32'(mp[i]));
                if (mk[i] == 0)
                    check($sformatf("gate_in_idle[%0d]", i), 32'(gin[i]), 32'd0);
                else if (mk[i] <= len)
                    check($sformatf("gate_in[%0d]", i), 32'(gin[i]), 32'((mk[i] - 1) / (s + 1)));
                if (mk[i] == 0 || mk[i] == len + 1)
                    check($sformatf("table[%0d]", i), 32'(tbl[i]), 32'(mt[i]));
            end
        end
    end

    int          dm [3];
    int          dc [3];
    logic [15:0] dt [3];
    logic        dp [3];
    int          dm2;
    int          idle0;

    // Accept a start at E0, then watch len+1 cycles; start is re-driven at cycles p1/p2 or held.
    task automatic sweep(input int len, input int p1, input int p2, input logic hold);
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            dm[i] = -1;
            dc[i] = 0;
            dt[i] = 16'h0;
            dp[i] = 1'b0;
        end
        dm2   = -1;
        idle0 = 0;
        for (int m = 0; m <= len; m++) begin
            @(negedge clk);
            start = hold | (m == p1) | (m == p2);
            if (dc[0] == 1 && !busy[0] && !done[0]) idle0++;
            for (int i = 0; i < 3; i++) begin
                if (done[i]) begin
                    dc[i]++;
                    if (dm[i] < 0) begin
                        dm[i] = m;
                        dt[i] = tbl[i];
                        dp[i] = pass[i];
                    end else if (i == 0 && dm2 < 0) begin
                        dm2 = m;
                    end
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_gate_in[%0d]", tag, i), 32'(gin[i]), 32'd0);
            check($sformatf("%s_busy[%0d]", tag, i), 32'(busy[i]), 32'd0);
            check($sformatf("%s_done[%0d]", tag, i), 32'(done[i]), 32'd0);
            check($sformatf("%s_table[%0d]", tag, i), 32'(tbl[i]), 32'd0);
            check($sformatf("%s_pass[%0d]", tag, i), 32'(pass[i]), 32'd0);
        end
    endtask

    initial begin
        bit reached;
        rst       = 1'b1;
        start     = 1'b0;
        mode_zero = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // AND4/OR4 at SETTLE=1, AND4 with first-cycle glitch at SETTLE=3; stray starts ignored.
        sweep(80, 10, 32, 1'b0);
        check("and4_done_cycle", 32'(dm[0]), 32'd32);
        check("or4_done_cycle", 32'(dm[1]), 32'd32);
        check("s3_done_cycle", 32'(dm[2]), 32'd64);
        check("and4_done_count", 32'(dc[0]), 32'd1);
        check("s3_done_count", 32'(dc[2]), 32'd1);
        check("and4_table", 32'(dt[0]), 32'h8000);
        check("and4_pass", 32'(dp[0]), 32'd1);
        check("or4_table", 32'(dt[1]), 32'hFFFE);
        check("or4_pass", 32'(dp[1]), 32'd1);
        check("s3_table", 32'(dt[2]), 32'h8000);
        check("s3_pass", 32'(dp[2]), 32'd1);

        mode_zero = 1'b1;
        sweep(70, -1, -1, 1'b0);
        check("stuck0_table", 32'(dt[0]), 32'h0000);
        check("stuck0_pass", 32'(dp[0]), 32'd0);
        check("stuck0_done_cycle", 32'(dm[0]), 32'd32);
        mode_zero = 1'b0;

        // Start held high: back-to-back sweeps, one idle cycle between them.
        sweep(110, -1, -1, 1'b1);
        check("held_done_count", 32'(dc[0]), 32'd3);
        check("held_done_spacing", 32'(dm2 - dm[0]), 32'd34);
        check("held_idle_cycles", 32'(idle0), 32'd1);

        // dut_a is mid-sweep again; hit it with reset once vector 7 is on the GUT.
        reached = 1'b0;
        for (int n = 0; n < 60 && !reached; n++) begin
            if (gin[0] == 4'd7) reached = 1'b1;
            else @(negedge clk);
        end
        check("reached_idx7", 32'(reached), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        sweep(70, -1, -1, 1'b0);
        check("post_rst_done_cycle", 32'(dm[0]), 32'd32);
        check("post_rst_table", 32'(dt[0]), 32'h8000);
        check("post_rst_pass", 32'(dp[0]), 32'd1);
        check("post_rst_s3_table", 32'(dt[2]), 32'h8000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
